adder_nbit: RTL and testbench
=============================

Name: adder_nbit

Overview:
- Parameterised unsigned N-bit adder producing a full N+1-bit sum, so no overflow is ever lost.
- Operands are sampled on a clock edge and the result is registered, for a fixed latency of 1 cycle.
- A valid flag travels alongside the data.
- Used as a generic arithmetic leaf, e.g. feeding display/BCD conversion datapaths.

Parameters:
- N, 10, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b valid this cycle.
- a  input  N  unsigned operand A.
- b  input  N  unsigned operand B.
- out_valid  output  1  sum holds a new result this cycle.
- sum  output  N+1  unsigned a+b; bit N is the carry-out.

Behaviour:
- Reset: while rst_n=0, sum=0 and out_valid=0 immediately, independent of clk. Release is synchronised by the next clk edge only; no other reset effect.
- Arithmetic: sum = zero-extend(a) + zero-extend(b), computed at N+1 bits.
  - Maximum result is 2^(N+1)-2, e.g. 2046 for N=10.
  - Never wraps; carry-out lands in sum[N].
- Operands wider than N at the driver are truncated modulo 2^N by the port width. The block performs no saturation.
- Latency:
  - On a rising edge with in_valid=1, sum <= a+b and out_valid <= 1.
  - On a rising edge with in_valid=0, sum holds its previous value and out_valid <= 0.
- Back-to-back valid inputs yield back-to-back results; throughput is 1 per cycle. No handshake back-pressure (no ready).
- Reset asserted mid-stream: the in-flight result is discarded. First valid result after release appears 1 cycle after the first sampled in_valid=1.
- X/unknown on a/b while in_valid=0 must not disturb sum.
- Carry chain: explicit ripple of 1-bit full adders built with generate; carry-in of bit 0 is 0. Synthesis may re-map it.
- No state machine; the only state is the sum register and the out_valid flop.

Decomposition:
- Shared package: no typedefs required. Optionally a constant DEFAULT_ADDER_WIDTH = 10.
- One sub-module is natural: full_adder_1bit (inputs x, y, cin; outputs s, cout). Instantiate it N times in a generate loop to form the combinational carry chain.
- The top-level holds only the output registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=5, b=5, toggling clk -> sum=0, out_valid=0. Then assert rst_n=0 asynchronously mid-cycle after a valid result -> sum clears to 0 before the next edge.
- Basic (N=10): a=300, b=150, in_valid=1 -> one cycle later sum=450, out_valid=1. Then a=10, b=904 -> 914.
- Driver truncation (N=10): drive 2250/1500 through 32-bit stimulus -> port sees a=202, b=476, sum=678. Drive 630/3000 -> a=630, b=952, sum=1582 (sum[10]=1).
- Carry-out: a=288, b=996 (from 500000/150500 truncated) -> sum=1284, sum[10]=1. Then a=1023, b=1023 -> sum=2046. Then a=0, b=0 -> sum=0.
- Valid gating: valid result 450, then in_valid=0 with a=1, b=1 for 3 cycles -> sum stays 450 and out_valid=0. Then a stream of 4 consecutive valid pairs yields 4 consecutive correct sums, each 1 cycle later.
- Parameter sweep: N=1 (all 4 combinations -> 0, 1, 1, 2) and N=16 with randomised a/b compared to a reference model, including a=0xFFFF, b=1 -> sum=0x10000.

Source files
------------

// File: rtl/adder_nbit_pkg.sv
// ----------------------------------------------------------------------------
// adder_nbit_pkg
// Shared constants for the registered N-bit adder and its carry-chain cell.
// No ports; imported by adder_nbit and full_adder_1bit.
// ----------------------------------------------------------------------------
package adder_nbit_pkg;

    // Operand width used when the instantiating design does not override N.
    localparam int DEFAULT_ADDER_WIDTH = 10;

    // Widest operand the adder is intended to be built with.
    localparam int MAX_ADDER_WIDTH = 64;

endpackage : adder_nbit_pkg

// File: rtl/adder_nbit_full_adder_1bit.sv
// ----------------------------------------------------------------------------
// full_adder_1bit
// One-bit full adder; the cell the ripple carry chain is built from.
// Ports:
//   x, y  : operand bits
//   cin   : carry in from the next-lower bit
//   s     : sum bit
//   cout  : carry out to the next-higher bit
// ----------------------------------------------------------------------------
module full_adder_1bit
    import adder_nbit_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic prop_s;

    // Propagate term is shared by the sum and the carry.
    assign prop_s = x ^ y;
    assign s      = prop_s ^ cin;
    assign cout   = (x & y) | (cin & prop_s);

endmodule : full_adder_1bit

// File: rtl/adder_nbit.sv
// ----------------------------------------------------------------------------
// adder_nbit
// Unsigned N-bit adder with a full N+1-bit registered result (carry-out kept
// in sum[N]) and a valid flag that travels with the data. Latency 1 cycle,
// throughput 1 per cycle, no back-pressure.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears sum and out_valid)
//   in_valid  : a/b are valid this cycle
//   a, b      : unsigned N-bit operands
//   out_valid : sum holds a new result this cycle
//   sum       : registered a+b, N+1 bits
// ----------------------------------------------------------------------------
module adder_nbit
    import adder_nbit_pkg::*;
#(
    parameter int N = DEFAULT_ADDER_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic [N:0]   sum
);

    logic [N:0]   carry_s;
    logic [N-1:0] sum_bits_s;
    logic [N:0]   sum_r;
    logic         out_valid_r;

    // Carry chain starts with no carry-in.
    assign carry_s[0] = 1'b0;

    // Ripple chain of full adders; the final carry becomes the result MSB.
    for (genvar i = 0; i < N; i++) begin : g_ripple
        full_adder_1bit u_fa (
            .x    (a[i]),
            .y    (b[i]),
            .cin  (carry_s[i]),
            .s    (sum_bits_s[i]),
            .cout (carry_s[i+1])
        );
    end

    // Result register: loads only on valid so unknown operands on idle cycles
    // never reach the output; the valid flag follows in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                sum_r <= {carry_s[N], sum_bits_s};
            end else begin
                sum_r <= sum_r;
            end
        end
    end

    assign sum       = sum_r;
    assign out_valid = out_valid_r;

endmodule : adder_nbit

// File: tb/tb_adder_nbit.sv
// ----------------------------------------------------------------------------
// tb_adder_nbit
// Scoreboard bench for adder_nbit at N=10, N=1 and N=16. Stimulus pushes the
// expected sum (plain modular integer arithmetic) and the cycle it is due;
// per-instance monitors pop and compare whenever out_valid is seen, and check
// that sum holds its last value while out_valid is low.
// ----------------------------------------------------------------------------
module tb_adder_nbit;

    typedef struct {
        longint exp;
        int     due;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    item_t  q10[$];
    item_t  q1[$];
    item_t  q16[$];
    item_t  it10;
    item_t  it1;
    item_t  it16;
    longint last10;
    longint last1;
    longint last16;

    logic        iv10, ov10;
    logic [9:0]  a10, b10;
    logic [10:0] sum10;
    logic        iv1, ov1;
    logic [0:0]  a1, b1;
    logic [1:0]  sum1;
    logic        iv16, ov16;
    logic [15:0] a16, b16;
    logic [16:0] sum16;

    adder_nbit #(.N(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv10), .a(a10), .b(b10),
        .out_valid(ov10), .sum(sum10)
    );

    adder_nbit #(.N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
        .out_valid(ov1), .sum(sum1)
    );

    adder_nbit #(.N(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16),
        .out_valid(ov16), .sum(sum16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drivers: the port slice models the driver-side truncation, the expected
    // value uses modulo arithmetic on the full driven value.
    task automatic drive10(input logic [31:0] av, input logic [31:0] bv, input logic v);
        item_t t;
        @(posedge clk);
        #1;
        a10 = av[9:0];
        b10 = bv[9:0];
        iv10 = v;
        if (v && rst_n) begin
            t.exp = longint'(av % 32'd1024) + longint'(bv % 32'd1024);
            t.due = cyc + 1;
            q10.push_back(t);
        end
    endtask

    task automatic drive1(input logic [31:0] av, input logic [31:0] bv, input logic v);
        item_t t;
        @(posedge clk);
        #1;
        a1 = av[0:0];
        b1 = bv[0:0];
        iv1 = v;
        if (v && rst_n) begin
            t.exp = longint'(av % 32'd2) + longint'(bv % 32'd2);
            t.due = cyc + 1;
            q1.push_back(t);
        end
    endtask

    task automatic drive16(input logic [31:0] av, input logic [31:0] bv, input logic v);
        item_t t;
        @(posedge clk);
        #1;
        a16 = av[15:0];
        b16 = bv[15:0];
        iv16 = v;
        if (v && rst_n) begin
            t.exp = longint'(av % 32'd65536) + longint'(bv % 32'd65536);
            t.due = cyc + 1;
            q16.push_back(t);
        end
    endtask

    // Monitor for the N=10 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov10) begin
                if (q10.size() == 0) begin
                    check("n10_spurious_valid", 1, 0);
                end else begin
                    it10 = q10.pop_front();
                    check("n10_sum", sum10, it10.exp);
                    check("n10_latency", cyc, it10.due);
                    last10 = it10.exp;
                end
            end else begin
                check("n10_hold", sum10, last10);
                if (q10.size() > 0 && q10[0].due <= cyc) begin
                    check("n10_out_valid", 0, 1);
                    it10 = q10.pop_front();
                end
            end
        end
    end

    // Monitor for the N=1 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov1) begin
                if (q1.size() == 0) begin
                    check("n1_spurious_valid", 1, 0);
                end else begin
                    it1 = q1.pop_front();
                    check("n1_sum", sum1, it1.exp);
                    check("n1_latency", cyc, it1.due);
                    last1 = it1.exp;
                end
            end else begin
                check("n1_hold", sum1, last1);
                if (q1.size() > 0 && q1[0].due <= cyc) begin
                    check("n1_out_valid", 0, 1);
                    it1 = q1.pop_front();
                end
            end
        end
    end

    // Monitor for the N=16 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov16) begin
                if (q16.size() == 0) begin
                    check("n16_spurious_valid", 1, 0);
                end else begin
                    it16 = q16.pop_front();
                    check("n16_sum", sum16, it16.exp);
                    check("n16_latency", cyc, it16.due);
                    last16 = it16.exp;
                end
            end else begin
                check("n16_hold", sum16, last16);
                if (q16.size() > 0 && q16[0].due <= cyc) begin
                    check("n16_out_valid", 0, 1);
                    it16 = q16.pop_front();
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        last10 = 0;
        last1 = 0;
        last16 = 0;
        iv10 = 1'b1; a10 = 10'd5; b10 = 10'd5;
        iv1 = 1'b0;  a1 = 1'b0;   b1 = 1'b0;
        iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0;

        // Held in reset with valid operands: nothing may come out.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sum", sum10, 0);
        check("reset_out_valid", ov10, 0);
        @(posedge clk);
        #1;
        iv10 = 1'b0;
        rst_n = 1'b1;

        // Basic sums.
        drive10(32'd300, 32'd150, 1'b1);
        drive10(32'd10, 32'd904, 1'b1);
        drive10(32'd0, 32'd0, 1'b0);

        // Asynchronous reset mid-cycle while a valid result is showing.
        drive10(32'd300, 32'd150, 1'b1);
        drive10(32'd1, 32'd1, 1'b0);
        @(negedge clk);
        #2;
        check("pre_reset_valid", ov10, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_sum", sum10, 0);
        check("async_reset_out_valid", ov10, 0);
        q10.delete();
        q1.delete();
        q16.delete();
        last10 = 0;
        last1 = 0;
        last16 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Driver truncation and carry-out.
        drive10(32'd2250, 32'd1500, 1'b1);
        drive10(32'd630, 32'd3000, 1'b1);
        drive10(32'd500000, 32'd150500, 1'b1);
        drive10(32'd1023, 32'd1023, 1'b1);
        drive10(32'd0, 32'd0, 1'b1);

        // Valid gating then a back-to-back stream.
        drive10(32'd300, 32'd150, 1'b1);
        repeat (3) drive10(32'd1, 32'd1, 1'b0);
        repeat (4) drive10($urandom, $urandom, 1'b1);

        // Unknown operands while idle must not disturb the held sum.
        @(posedge clk);
        #1;
        a10 = 'x;
        b10 = 'x;
        iv10 = 1'b0;
        repeat (40) drive10($urandom, $urandom, 1'($urandom_range(0, 1)));
        drive10(32'd0, 32'd0, 1'b0);

        // N=1: every operand combination.
        for (int i = 0; i < 4; i++) begin
            drive1(32'(i >> 1), 32'(i & 1), 1'b1);
        end
        drive1(32'd1, 32'd1, 1'b0);

        // N=16: carry into bit 16, then random traffic.
        drive16(32'h0000_FFFF, 32'd1, 1'b1);
        repeat (50) drive16($urandom, $urandom, 1'($urandom_range(0, 1)));
        drive16(32'd0, 32'd0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("q10_drained", q10.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q16_drained", q16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_nbit
